// File: rtl/v16_pulse_gen.sv
// Synthetic detector-pulse source: step-rise, exponential-decay pulses
// on a programmable baseline, with pile-up by superposition.
module v16_pulse_gen #(
  parameter int DATA_W      = 12,
  parameter int FRAC_W      = 8,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLDOFF     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] baseline,
  input  logic              pulse_valid,
  output logic              pulse_ready,
  input  logic [DATA_W-1:0] pulse_amp,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy
);

  localparam int AW = DATA_W + FRAC_W;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q;
  logic              busy_q, busy_d;

  logic              apply;
  logic [AW-1:0]     dec;
  logic [AW:0]       sum;
  logic [AW-1:0]     acc_n;
  logic [DATA_W:0]   osum;
  logic [DATA_W-1:0] data_n;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    apply   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pulse_valid && ready_q) begin
          pend_d  = pulse_amp;
          state_d = PEND;
        end
      end
      (state_q == PEND): begin
        if (sample_en) begin
          apply   = 1'b1;
          hold_d  = HOLD_INIT;
          state_d = (HOLDOFF == 0) ? IDLE : HOLD;
        end
      end
      (state_q == HOLD): begin
        if (sample_en) begin
          hold_d = hold_q - HW'(1);
          if (hold_q <= HW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Forced minimum decay of 1 lets the tail settle exactly at zero.
  always_comb begin
    dec = acc_q >> DECAY_SHIFT;
    if (dec == '0 && acc_q != '0) dec = AW'(1);
    sum = {1'b0, acc_q - dec};
    if (apply) sum = sum + {1'b0, pend_q, {FRAC_W{1'b0}}};
    acc_n  = sum[AW] ? '1 : sum[AW-1:0];
    osum   = {1'b0, baseline} + {1'b0, acc_n[AW-1:FRAC_W]};
    data_n = osum[DATA_W] ? '1 : osum[DATA_W-1:0];
  end

  always_comb begin
    acc_d   = sample_en ? acc_n : acc_q;
    data_d  = sample_en ? data_n : data_q;
    ready_d = (state_d == IDLE);
    busy_d  = (acc_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pend_q  <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      valid_q <= sample_en;
      busy_q  <= busy_d;
    end
  end

  assign pulse_ready = ready_q;
  assign data_out    = data_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_v16_pulse_gen.sv
// Bench for v16_pulse_gen: reference model feeding a scoreboard queue,
// plus a table of hand-derived samples for the first pulse.
module tb_v16_pulse_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] baseline = '0;
  logic        pulse_valid = 1'b0;
  logic        pulse_ready;
  logic [11:0] pulse_amp = '0;
  logic [11:0] data_out;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  v16_pulse_gen dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .baseline    (baseline),
    .pulse_valid (pulse_valid),
    .pulse_ready (pulse_ready),
    .pulse_amp   (pulse_amp),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic        ov;
    logic        rdy;
    logic        busy;
  } exp_t;

  typedef struct {
    logic        se;
    logic [11:0] bl;
    logic        pv;
    logic [11:0] amp;
    logic [11:0] exp_data;
    logic        exp_rdy;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];

  int m_acc, m_pend, m_state, m_hold, m_data;
  bit m_ready, m_busy, m_ov;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_pend = 0; m_state = 0; m_hold = 0; m_data = 0;
    m_ready = 0; m_busy = 0; m_ov = 0;
  endtask

  task automatic step(input logic se, input logic [11:0] bl,
                      input logic pv, input logic [11:0] amp);
    int acc_n, st_n, pend_n, hold_n, d, o;
    exp_t e, g;
    @(negedge clk);
    sample_en = se; baseline = bl; pulse_valid = pv; pulse_amp = amp;
    acc_n = m_acc; st_n = m_state; pend_n = m_pend; hold_n = m_hold;
    if (se) begin
      d = m_acc / 16;
      if (d == 0 && m_acc != 0) d = 1;
      acc_n = m_acc - d;
      if (m_state == 1) acc_n += m_pend * 256;
      if (acc_n > 1048575) acc_n = 1048575;
      o = bl + acc_n / 256;
      m_data = (o > 4095) ? 4095 : o;
    end
    if (m_state == 0 && pv && m_ready) begin
      pend_n = amp; st_n = 1;
    end else if (m_state == 1 && se) begin
      hold_n = 4; st_n = 2;
    end else if (m_state == 2 && se) begin
      hold_n = m_hold - 1;
      if (hold_n == 0) st_n = 0;
    end
    m_acc = acc_n; m_state = st_n; m_pend = pend_n; m_hold = hold_n;
    m_ready = (st_n == 0);
    m_busy = (acc_n != 0) || (st_n != 0);
    m_ov = se;
    e.data = 12'(m_data); e.ov = m_ov; e.rdy = m_ready; e.busy = m_busy;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("data_out", data_out, g.data);
    chk("out_valid", out_valid, g.ov);
    chk("pulse_ready", pulse_ready, g.rdy);
    chk("busy", busy, g.busy);
  endtask

  task automatic drain(input logic [11:0] bl);
    int n = 0;
    while ((m_busy || !m_ready) && n < 600) begin
      step(1'b1, bl, 1'b0, 12'd0);
      n++;
    end
    chk("drain_budget", (n < 600) ? 1 : 0, 1);
    chk("drain_busy", busy, 0);
  endtask

  // Called right after a step (posedge+1); releases before next negedge.
  task automatic pulse_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_ready", pulse_ready, 0);
    model_reset();
    #1 reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 12'd100, 1'b1, 12'd1000, 12'd100,  1'b0};
    tbl[1] = '{1'b1, 12'd100, 1'b0, 12'd0,    12'd1100, 1'b0};
    tbl[2] = '{1'b1, 12'd100, 1'b0, 12'd0,    12'd1037, 1'b0};
    tbl[3] = '{1'b1, 12'd100, 1'b0, 12'd0,    12'd978,  1'b0};
    tbl[4] = '{1'b1, 12'd100, 1'b0, 12'd0,    12'd923,  1'b0};
    tbl[5] = '{1'b1, 12'd100, 1'b0, 12'd0,    12'd872,  1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    for (int i = 0; i < 4; i++) step(1'b1, 12'd100, 1'b0, 12'd0);
    chk("idle_data", data_out, 100);
    chk("idle_ready", pulse_ready, 1);

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].se, tbl[i].bl, tbl[i].pv, tbl[i].amp);
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].exp_data);
      chk($sformatf("tbl%0d_ready", i), pulse_ready, tbl[i].exp_rdy);
    end
    drain(12'd100);
    chk("drain_base", data_out, 100);

    step(1'b1, 12'd0, 1'b1, 12'd1);
    for (int i = 0; i < 200; i++) step(1'b1, 12'd0, 1'b0, 12'd0);
    chk("tail_data", data_out, 0);
    chk("tail_busy", busy, 0);

    step(1'b1, 12'd0, 1'b1, 12'd2000);
    for (int i = 0; i < 8; i++) step(1'b1, 12'd0, 1'b1, 12'd2000);
    drain(12'd0);

    step(1'b1, 12'd100, 1'b1, 12'd4095);
    step(1'b1, 12'd100, 1'b0, 12'd0);
    chk("clamp_data", data_out, 4095);
    for (int i = 0; i < 8; i++) step(1'b1, 12'd100, 1'b1, 12'd4095);
    drain(12'd100);

    for (int i = 0; i < 40; i++)
      step((i % 4) == 0, 12'd50, (i == 4), 12'd300);
    drain(12'd50);

    step(1'b1, 12'd100, 1'b1, 12'd0);
    chk("amp0_busy", busy, 1);
    drain(12'd100);
    chk("amp0_data", data_out, 100);

    step(1'b1, 12'd100, 1'b1, 12'd600);
    step(1'b1, 12'd100, 1'b0, 12'd0);
    chk("mid_data", data_out, 700);
    step(1'b1, 12'd100, 1'b0, 12'd0);
    pulse_reset();
    step(1'b1, 12'd100, 1'b0, 12'd0);
    step(1'b1, 12'd100, 1'b0, 12'd0);
    chk("post_rst_data", data_out, 100);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 3) == 0), 12'($urandom_range(0, 4095)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
